// File: rtl/mmul_conv_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : mmul_conv_sequencer
//  Brief    : Sequences one convolution window through the shared 9x9/3x3
//             multi-multiplier and accumulates its partial products. Accepts
//             a job config, streams operands to the multiplier, tracks
//             in-flight products over MUL_LAT and returns one accumulated
//             result per job on a valid/ready output.
//  Options  : MMSEQ_SAT_EN - saturating accumulate (default: wrap-around)
//  Revision : 1.0 - initial release
// ============================================================================
module mmul_conv_sequencer #(
  parameter int TAP_W   = 8,
  parameter int ACC_W   = 24,   // must be wider than the 16-bit product
  parameter int MUL_LAT = 1     // 1..4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    soft_clr,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [1:0]              cfg_convtype,
  input  logic [TAP_W-1:0]        cfg_taps,
  output logic                    cfg_err,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [8:0]              s_d,
  input  logic [8:0]              s_w1,
  input  logic [8:0]              s_w2,
  input  logic [8:0]              s_w3,
  output logic [8:0]              mm_d,
  output logic [8:0]              mm_w1,
  output logic [8:0]              mm_w2,
  output logic [8:0]              mm_w3,
  output logic [1:0]              mm_convtype,
  input  logic [15:0]             mm_mul,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic signed [ACC_W-1:0] m_acc,
  output logic                    busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [TAP_W-1:0]   r_taps;
  logic [TAP_W-1:0]   r_issued;
  logic [TAP_W-1:0]   w_issued_inc;
  logic [MUL_LAT:0]   r_pipe;
  logic [ACC_W-1:0]   r_acc;
  logic [ACC_W-1:0]   w_acc_nxt;
  logic [ACC_W-1:0]   w_mul_ext;
  logic [8:0]         r_mm_d, r_mm_w1, r_mm_w2, r_mm_w3;
  logic [1:0]         r_mm_convtype;
  logic               r_cfg_err;

  logic               w_cfg_legal;
  logic               w_cfg_go;
  logic               w_cfg_bad;
  logic               w_issue_open;
  logic               w_accept;
  logic               w_last;
  logic               w_pipe_empty;

  // Config legality: only 9x9 (00) and 3x3 (01) modes, at least one tap.
  assign w_cfg_legal  = (cfg_convtype[1] == 1'b0) && (cfg_taps != '0);
  assign w_cfg_go     = (r_state == ST_IDLE) && cfg_valid &&  w_cfg_legal;
  assign w_cfg_bad    = (r_state == ST_IDLE) && cfg_valid && !w_cfg_legal;

  // Operand issue: a soft_clr in the same cycle discards the accepted beat.
  assign w_issue_open = (r_state == ST_RUN) && (r_issued < r_taps);
  assign w_accept     = s_valid && w_issue_open && !soft_clr;
  assign w_issued_inc = r_issued + TAP_W'(1);
  assign w_last       = w_accept && (w_issued_inc == r_taps);
  assign w_pipe_empty = (r_pipe == '0);

  assign s_ready      = w_issue_open;
  assign cfg_err      = r_cfg_err;
  assign m_acc        = r_acc;
  assign mm_d         = r_mm_d;
  assign mm_w1        = r_mm_w1;
  assign mm_w2        = r_mm_w2;
  assign mm_w3        = r_mm_w3;
  assign mm_convtype  = r_mm_convtype;

  // Accumulator update: sign-extend the product, then wrap or clamp.
  always_comb begin
    w_mul_ext = {{(ACC_W-16){mm_mul[15]}}, mm_mul};
`ifdef MMSEQ_SAT_EN
    w_acc_nxt = sat_add(r_acc, w_mul_ext);
`else
    w_acc_nxt = r_acc + w_mul_ext;
`endif
  end

`ifdef MMSEQ_SAT_EN
  localparam logic [ACC_W-1:0] c_ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] c_ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // One guard bit exposes overflow: the top two sum bits disagree.
  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [ACC_W-1:0] b);
    logic [ACC_W:0] sum;
    sum = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    if (sum[ACC_W] != sum[ACC_W-1]) begin
      sat_add = sum[ACC_W] ? c_ACC_MIN : c_ACC_MAX;
    end else begin
      sat_add = sum[ACC_W-1:0];
    end
  endfunction
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and state-decoded handshake outputs; soft_clr wins over all.
  always_comb begin
    w_state_nxt = r_state;
    cfg_ready   = 1'b0;
    m_valid     = 1'b0;
    busy        = 1'b1;
    case (r_state)
      ST_IDLE: begin
        cfg_ready = 1'b1;
        busy      = 1'b0;
        if (w_cfg_go) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (w_last) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_pipe_empty) w_state_nxt = ST_OUT;
      end
      ST_OUT: begin
        m_valid = 1'b1;
        if (m_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (soft_clr) w_state_nxt = ST_IDLE;
  end

  // Datapath: job config latch, operand registers, valid pipe, accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_taps        <= '0;
      r_issued      <= '0;
      r_pipe        <= '0;
      r_acc         <= '0;
      r_mm_d        <= '0;
      r_mm_w1       <= '0;
      r_mm_w2       <= '0;
      r_mm_w3       <= '0;
      r_mm_convtype <= 2'b00;
      r_cfg_err     <= 1'b0;
    end else if (soft_clr) begin
      r_issued      <= '0;
      r_pipe        <= '0;
      r_acc         <= '0;
      r_mm_d        <= '0;
      r_mm_w1       <= '0;
      r_mm_w2       <= '0;
      r_mm_w3       <= '0;
      r_cfg_err     <= 1'b0;
    end else begin
      r_cfg_err <= w_cfg_bad;
      // Idle cycles feed zeros so the multiplier never sees stale operands.
      r_mm_d    <= w_accept ? s_d  : 9'd0;
      r_mm_w1   <= w_accept ? s_w1 : 9'd0;
      r_mm_w2   <= w_accept ? s_w2 : 9'd0;
      r_mm_w3   <= w_accept ? s_w3 : 9'd0;
      // Bit k marks a product issued k+1 edges ago; the top bit lines up
      // with mm_mul carrying that product.
      r_pipe    <= {r_pipe[MUL_LAT-1:0], w_accept};
      if (w_cfg_go) begin
        r_mm_convtype <= cfg_convtype;
        r_taps        <= cfg_taps;
        r_issued      <= '0;
        r_acc         <= '0;
      end else begin
        if (w_accept)        r_issued <= w_issued_inc;
        if (r_pipe[MUL_LAT]) r_acc    <= w_acc_nxt;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mmul_conv_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mmul_conv_sequencer
//  Brief    : Self-checking bench for mmul_conv_sequencer. A registered
//             multiplier model closes the loop; expected job results are
//             queued at issue and popped by an output monitor.
//  Options  : MMSEQ_SAT_EN - selects the saturating reference arithmetic
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mmul_conv_sequencer;

  localparam int TAP_W   = 8;
  localparam int ACC_W   = 17;
  localparam int MUL_LAT = 1;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    soft_clr = 1'b0;
  logic                    cfg_valid = 1'b0;
  logic                    cfg_ready;
  logic [1:0]              cfg_convtype = 2'b00;
  logic [TAP_W-1:0]        cfg_taps = '0;
  logic                    cfg_err;
  logic                    s_valid = 1'b0;
  logic                    s_ready;
  logic [8:0]              s_d = '0, s_w1 = '0, s_w2 = '0, s_w3 = '0;
  logic [8:0]              mm_d, mm_w1, mm_w2, mm_w3;
  logic [1:0]              mm_convtype;
  logic [15:0]             mm_mul = '0;
  logic                    m_valid;
  logic                    m_ready = 1'b0;
  logic signed [ACC_W-1:0] m_acc;
  logic                    busy;

  int errors = 0;
  int checks = 0;
  int sb[$];
  int job_d[8];
  int job_w[8];

  mmul_conv_sequencer #(.TAP_W(TAP_W), .ACC_W(ACC_W), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .soft_clr(soft_clr),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_convtype(cfg_convtype),
    .cfg_taps(cfg_taps), .cfg_err(cfg_err),
    .s_valid(s_valid), .s_ready(s_ready), .s_d(s_d),
    .s_w1(s_w1), .s_w2(s_w2), .s_w3(s_w3),
    .mm_d(mm_d), .mm_w1(mm_w1), .mm_w2(mm_w2), .mm_w3(mm_w3),
    .mm_convtype(mm_convtype), .mm_mul(mm_mul),
    .m_valid(m_valid), .m_ready(m_ready), .m_acc(m_acc), .busy(busy)
  );

  always #5 clk = ~clk;

  // Registered multiplier: d * signed(w1), truncated to 16 bits.
  always @(posedge clk) begin
    int p;
    p = int'(mm_d) * int'($signed(mm_w1));
    mm_mul <= p[15:0];
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference arithmetic: 16-bit signed product, ACC_W-bit accumulate.
  function automatic int prod16(input int d, input int w);
    int p;
    logic [15:0] t;
    p = d * w;
    t = p[15:0];
    return int'($signed(t));
  endfunction

  function automatic int acc_step(input int acc, input int p);
    int s;
    logic [ACC_W-1:0] t;
    s = acc + p;
`ifdef MMSEQ_SAT_EN
    if (s > (1 << (ACC_W-1)) - 1) s = (1 << (ACC_W-1)) - 1;
    if (s < -(1 << (ACC_W-1)))    s = -(1 << (ACC_W-1));
    t = s[ACC_W-1:0];
`else
    t = s[ACC_W-1:0];
`endif
    return int'($signed(t));
  endfunction

  // Output monitor: every result handshake consumes one expectation.
  always @(negedge clk) begin
    int e;
    if (rst_n && m_valid && m_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL result: got %0d, expected no output", int'(m_acc));
      end else begin
        e = sb.pop_front();
        check("result", int'(m_acc), e);
      end
    end
  end

  task automatic do_cfg(input int ct, input int taps);
    cfg_valid    = 1'b1;
    cfg_convtype = ct[1:0];
    cfg_taps     = taps[TAP_W-1:0];
    @(posedge clk); #1;
    cfg_valid    = 1'b0;
  endtask

  // Presents one operand and returns #1 after the edge that accepted it.
  task automatic send_op(input int d, input int w);
    logic [31:0] dv, wv;
    bit done;
    dv = d;
    wv = w;
    done = 0;
    s_valid = 1'b1;
    s_d  = dv[8:0];
    s_w1 = wv[8:0];
    s_w2 = 9'($urandom);
    s_w3 = 9'($urandom);
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      done = s_ready;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    if (!done) check("s_ready_timeout", 0, 1);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Drives m_ready until all queued results are consumed and DUT is idle.
  task automatic drain_out(input bit rand_ready);
    bit done;
    done = 0;
    for (int n = 0; n < 300 && !done; n++) begin
      if (sb.size() == 0 && !busy) begin
        done = 1;
      end else begin
        m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        @(posedge clk); #1;
      end
    end
    m_ready = 1'b0;
    check("drain_pending", sb.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen, exp, n, ct;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",     int'(busy), 0);
    check("rst_cfg_rdy",  int'(cfg_ready), 1);
    check("rst_cfg_err",  int'(cfg_err), 0);
    check("rst_s_ready",  int'(s_ready), 0);
    check("rst_m_valid",  int'(m_valid), 0);
    check("rst_m_acc",    int'(m_acc), 0);
    check("rst_mm_d",     int'(mm_d), 0);
    check("rst_mm_ct",    int'(mm_convtype), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic job: 2*5 + 3*(-1) + 4*10 = 47, result 3 clk after last accept.
    m_ready = 1'b1;
    sb.push_back(47);
    do_cfg(0, 3);
    @(negedge clk);
    check("run_busy",    int'(busy), 1);
    check("run_cfg_rdy", int'(cfg_ready), 0);
    check("run_s_ready", int'(s_ready), 1);
    check("run_mm_ct",   int'(mm_convtype), 0);
    @(posedge clk); #1;
    send_op(2, 5);
    send_op(3, -1);
    send_op(4, 10);
    @(negedge clk);
    check("drain_s_ready", int'(s_ready), 0);
    @(negedge clk);
    @(negedge clk);
    check("lat_before", int'(m_valid), 0);
    @(negedge clk);
    check("lat_at", int'(m_valid), 1);
    @(posedge clk); #1;
    drain_out(0);

    // Gapped operands and output backpressure.
    m_ready = 1'b0;
    sb.push_back(400);
    do_cfg(0, 4);
    for (int i = 0; i < 4; i++) begin
      send_op(10, 10);
      idle_cycles(2);
    end
    seen = 0;
    for (int i = 0; i < 20 && !m_valid; i++) @(negedge clk);
    check("stall_valid", int'(m_valid), 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_valid", int'(m_valid), 1);
      check("hold_acc", int'(m_acc), 400);
    end
    @(posedge clk); #1;
    m_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("post_m_valid", int'(m_valid), 0);
    check("post_busy",    int'(busy), 0);
    check("post_cfg_rdy", int'(cfg_ready), 1);
    @(posedge clk); #1;
    m_ready = 1'b0;

    // Illegal configurations: convtype 10, then taps 0.
    for (int k = 0; k < 2; k++) begin
      cfg_valid    = 1'b1;
      cfg_convtype = (k == 0) ? 2'b10 : 2'b01;
      cfg_taps     = (k == 0) ? 8'd4 : 8'd0;
      @(negedge clk);
      check("bad_err_pre", int'(cfg_err), 0);
      @(posedge clk); #1;
      cfg_valid = 1'b0;
      @(negedge clk);
      check("bad_err",     int'(cfg_err), 1);
      check("bad_busy",    int'(busy), 0);
      check("bad_s_ready", int'(s_ready), 0);
      check("bad_mm_ct",   int'(mm_convtype), 0);
      @(negedge clk);
      check("bad_err_end", int'(cfg_err), 0);
      check("bad_busy2",   int'(busy), 0);
      @(posedge clk); #1;
    end

    // Overflow: four products of 217*151 = 32767.
`ifdef MMSEQ_SAT_EN
    sb.push_back(65535);
`else
    sb.push_back(-4);
`endif
    do_cfg(0, 4);
    for (int i = 0; i < 4; i++) send_op(217, 151);
    drain_out(0);

    // soft_clr after 2 of 5 taps.
    do_cfg(0, 5);
    send_op(3, 3);
    send_op(4, 4);
    soft_clr = 1'b1;
    @(posedge clk); #1;
    soft_clr = 1'b0;
    @(negedge clk);
    check("clr_busy",    int'(busy), 0);
    check("clr_cfg_rdy", int'(cfg_ready), 1);
    check("clr_m_acc",   int'(m_acc), 0);
    check("clr_mm_d",    int'(mm_d), 0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (m_valid) seen++;
    end
    check("clr_no_valid", seen, 0);
    @(posedge clk); #1;
    sb.push_back(-7);
    do_cfg(0, 1);
    send_op(1, -7);
    drain_out(0);

    // Asynchronous reset while draining.
    do_cfg(1, 2);
    send_op(5, 6);
    send_op(7, 8);
    check("pre_rst_busy",  int'(busy), 1);
    check("pre_rst_mm_ct", int'(mm_convtype), 1);
    rst_n = 1'b0;
    #1;
    check("arst_busy",    int'(busy), 0);
    check("arst_cfg_rdy", int'(cfg_ready), 1);
    check("arst_m_valid", int'(m_valid), 0);
    check("arst_m_acc",   int'(m_acc), 0);
    check("arst_mm_d",    int'(mm_d), 0);
    check("arst_mm_w1",   int'(mm_w1), 0);
    check("arst_mm_ct",   int'(mm_convtype), 0);
    check("arst_s_ready", int'(s_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(2);

    // Randomized jobs against the reference model.
    for (int j = 0; j < 20; j++) begin
      n   = $urandom_range(1, 6);
      ct  = $urandom_range(0, 1);
      exp = 0;
      for (int i = 0; i < n; i++) begin
        job_d[i] = $urandom_range(0, 511);
        job_w[i] = $urandom_range(0, 511) - 256;
        exp = acc_step(exp, prod16(job_d[i], job_w[i]));
      end
      sb.push_back(exp);
      do_cfg(ct, n);
      for (int i = 0; i < n; i++) begin
        send_op(job_d[i], job_w[i]);
        idle_cycles($urandom_range(0, 2));
      end
      drain_out(1);
      check("rand_mm_ct", int'(mm_convtype), ct);
    end

    idle_cycles(3);
    check("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mmul_conv_sequencer.md
Name: mmul_conv_sequencer

Overview:
- Controller that sequences one convolution window through the shared 9x9/3x3 multi-multiplier and accumulates the partial products.
- Accepts a job config (mode, tap count) and a valid/ready operand stream. Drives the multiplier's operand and mode inputs, tracks in-flight products over the multiplier latency, and returns one accumulated result per job on a valid/ready output.
- Sits between the window/weight fetch logic and the multiplier in each conv lane.

Parameters:
- TAP_W, 8: width of tap count; max taps per job = 2^TAP_W-1.
- ACC_W, 24: accumulator/result width, signed.
- MUL_LAT, 1: multiplier clock latency, operand sample to mm_mul valid; legal range 1..4.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- soft_clr  in  1  synchronous abort; returns to IDLE, discards in-flight data.
- cfg_valid  in  1  job config valid.
- cfg_ready  out  1  high in IDLE only.
- cfg_convtype  in  2  00 = 9x9, 01 = 3x3; 10/11 illegal.
- cfg_taps  in  TAP_W  taps in the job; 0 illegal.
- cfg_err  out  1  one-cycle pulse on an illegal config accept.
- s_valid  in  1  operand valid.
- s_ready  out  1  operand ready.
- s_d  in  9  unsigned data.
- s_w1, s_w2, s_w3  in  9 each  signed weights.
- mm_d, mm_w1, mm_w2, mm_w3  out  9 each  registered operands to the multiplier.
- mm_convtype  out  2  registered mode to the multiplier.
- mm_mul  in  16  multiplier result, signed.
- m_valid  out  1  result valid.
- m_ready  in  1  result accepted.
- m_acc  out  ACC_W  accumulated result, signed.
- busy  out  1  state != IDLE.

Behaviour:
- Reset values (async, rst_n low): state IDLE; cfg_err=0; s_ready=0; m_valid=0; m_acc=0; mm_d/mm_w*=0; mm_convtype=00; busy=0; issue count=0; in-flight pipe cleared.
- States:
  - IDLE: cfg_ready=1.
    - Legal cfg_valid: latch convtype to mm_convtype, latch taps, clear accumulator and issue counter, go to RUN.
    - Illegal cfg (convtype 1x, or taps=0): pulse cfg_err next cycle, stay in IDLE.
  - RUN: s_ready=1 while issued<taps.
    - On s_valid&&s_ready at edge T: register s_* into mm_*, increment issued, push 1 into the valid pipe.
    - Cycles with no accept: mm_d/mm_w* driven 0, push 0.
    - After the accept that makes issued==taps: go to DRAIN; s_ready drops the same edge.
  - DRAIN: s_ready=0; wait until the valid pipe is empty, then go to OUT.
  - OUT: m_valid=1, m_acc stable.
    - On m_ready: go to IDLE with m_valid=0.
    - Same-cycle cfg is not accepted (cfg_ready=0 in OUT).
- Valid pipe is MUL_LAT+1 deep. An operand accepted at edge T is added at edge T+1+MUL_LAT: acc += sign-extended mm_mul.
- Timing: with MUL_LAT=1, last accept at edge T gives m_valid high after edge T+3.
- Arithmetic: mm_mul is sign-extended to ACC_W. The add wraps modulo 2^ACC_W (see optional feature).
- Back-to-back operands are accepted every cycle; throughput is 1 tap/clk.
- soft_clr: highest priority synchronous event. Next state is IDLE, pipe cleared, m_valid=0, m_acc=0, mm_*=0. Overrides a same-cycle accept or handshake.
- rst_n is asserted mid-job: immediate return to the reset values; the job is lost.
- taps=1: RUN lasts exactly one accept.
- mm_convtype holds the last legal config until the next legal config or reset.

Optional Feature:
- Macro MMSEQ_SAT_EN.
- Defined: each accumulate saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; once clamped, later adds continue from the clamped value.
- Undefined: the accumulate wraps modulo 2^ACC_W; no saturation logic is present.

Test Plan:
- Bench multiplier model: registered, MUL_LAT=1, mm_mul = d*signed(w1) truncated to 16 bits.
- Basic job: cfg 00, taps=3; operands (d,w1) = (2,5), (3,-1), (4,10) back-to-back -> m_acc=47; m_valid 3 clk after the last accept; mm_convtype=00.
- Stalls and backpressure: taps=4, s_valid gapped 1-on/2-off, all products 100; hold m_ready=0 for 5 clk -> m_acc=400 held stable; IDLE reached the clk after m_ready; cfg_ready returns.
- Illegal config: cfg_convtype=10, taps=4 -> cfg_err pulses 1 clk, busy stays 0, s_ready stays 0. Repeat with cfg 01, taps=0 -> same response.
- Overflow, ACC_W=17: taps=4, each product 32767 -> without MMSEQ_SAT_EN m_acc = -4 (0x1FFFC); with MMSEQ_SAT_EN m_acc = 65535.
- Aborts:
  - soft_clr asserted after 2 of 5 taps -> IDLE next clk; m_valid never rises; a following job (taps=1, d=1, w1=-7) -> m_acc=-7.
  - rst_n pulsed low in DRAIN -> all outputs at reset values immediately.
